// File: rtl/proc_ctrl_multi_cnt_pkg.sv
// Shared widths and helpers for the multi-channel occupancy counter.
// Optional high-water-mark feature is enabled by defining PROC_CTRL_CNT_HWM_EN.
package proc_ctrl_multi_cnt_pkg;

    function automatic int unsigned ceil_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) r++;
        return r;
    endfunction

    // Low bit of channel ch inside a packed per-channel vector of width w.
    function automatic int unsigned slice_lo(input int unsigned ch, input int unsigned w);
        return ch * w;
    endfunction

    localparam int unsigned DEF_NCHAN  = 4;
    localparam int unsigned DEF_LIMIT  = 8;
    localparam int unsigned DEF_MAXN   = 2;
    localparam int unsigned DEF_AF_LVL = 6;
    localparam int unsigned DEF_AE_LVL = 2;
    localparam int unsigned DEF_NB     = ceil_log2(DEF_MAXN + 1);
    localparam int unsigned DEF_CB     = ceil_log2(DEF_LIMIT + 1);

endpackage

// File: rtl/proc_ctrl_multi_cnt_if.sv
// Packed per-channel request/status bundle between a client and the counter.
// hwm carries data only when PROC_CTRL_CNT_HWM_EN is defined.
interface proc_ctrl_multi_cnt_if
    import proc_ctrl_multi_cnt_pkg::*;
#(
    parameter int unsigned NCHAN = DEF_NCHAN,
    parameter int unsigned NB    = DEF_NB,
    parameter int unsigned CB    = DEF_CB
);
    logic [NCHAN*NB-1:0] enq_n;
    logic [NCHAN*NB-1:0] deq_n;
    logic [NCHAN-1:0]    flush;
    logic [NCHAN-1:0]    err_clr;
    logic [NCHAN*CB-1:0] count;
    logic [NCHAN-1:0]    empty;
    logic [NCHAN-1:0]    full;
    logic [NCHAN-1:0]    almost_full;
    logic [NCHAN-1:0]    almost_empty;
    logic [NCHAN-1:0]    space_ok;
    logic [NCHAN-1:0]    ovf_err;
    logic [NCHAN-1:0]    unf_err;
    logic [NCHAN*CB-1:0] hwm;

    modport master (
        output enq_n, deq_n, flush, err_clr,
        input  count, empty, full, almost_full, almost_empty,
               space_ok, ovf_err, unf_err, hwm
    );

    modport slave (
        input  enq_n, deq_n, flush, err_clr,
        output count, empty, full, almost_full, almost_empty,
               space_ok, ovf_err, unf_err, hwm
    );
endinterface

// File: rtl/proc_ctrl_multi_cnt_chan.sv
// One occupancy channel: saturating count, level flags, sticky errors.
// High-water mark register present only when PROC_CTRL_CNT_HWM_EN is defined.
module proc_ctrl_cnt_chan
    import proc_ctrl_multi_cnt_pkg::*;
#(
    parameter int unsigned LIMIT  = DEF_LIMIT,
    parameter int unsigned MAXN   = DEF_MAXN,
    parameter int unsigned AF_LVL = DEF_AF_LVL,
    parameter int unsigned AE_LVL = DEF_AE_LVL,
    parameter int unsigned NB     = DEF_NB,
    parameter int unsigned CB     = DEF_CB
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [NB-1:0] enq_i,
    input  logic [NB-1:0] deq_i,
    input  logic          flush_i,
    input  logic          err_clr_i,
    output logic [CB-1:0] count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          almost_full_o,
    output logic          almost_empty_o,
    output logic          space_ok_o,
    output logic          ovf_err_o,
    output logic          unf_err_o,
    output logic [CB-1:0] hwm_o
);
    localparam int unsigned SW = CB + 2;

    logic [CB-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d, unf_q, unf_d;
    logic                 ovf_hit, unf_hit;
    logic signed [SW-1:0] nxt;

    always_comb begin
        nxt     = $signed(SW'(count_q)) + $signed(SW'(enq_i)) - $signed(SW'(deq_i));
        count_d = count_q;
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        if (flush_i) begin
            count_d = '0;
        end else if (nxt > $signed(SW'(LIMIT))) begin
            count_d = CB'(LIMIT);
            ovf_hit = 1'b1;
        end else if (nxt < 0) begin
            count_d = '0;
            unf_hit = 1'b1;
        end else begin
            count_d = nxt[CB-1:0];
        end
        // A fresh error outranks a simultaneous clear.
        ovf_d = ovf_hit | (ovf_q & ~err_clr_i);
        unf_d = unf_hit | (unf_q & ~err_clr_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        count_o        = count_q;
        empty_o        = (count_q == '0);
        full_o         = (count_q == CB'(LIMIT));
        almost_full_o  = (count_q >= CB'(AF_LVL));
        almost_empty_o = (count_q <= CB'(AE_LVL));
        space_ok_o     = (count_q <= CB'(LIMIT - MAXN));
        ovf_err_o      = ovf_q;
        unf_err_o      = unf_q;
    end

`ifdef PROC_CTRL_CNT_HWM_EN
    logic [CB-1:0] hwm_q, hwm_d;
    logic [CB-1:0] hwm_base;

    // err_clr restarts the mark from the current count, still tracking this cycle's update.
    always_comb begin
        hwm_base = err_clr_i ? count_q : hwm_q;
        hwm_d    = (count_d > hwm_base) ? count_d : hwm_base;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) hwm_q <= '0;
        else       hwm_q <= hwm_d;
    end

    assign hwm_o = hwm_q;
`else
    assign hwm_o = '0;
`endif

endmodule

// File: rtl/proc_ctrl_multi_cnt.sv
// Multi-channel occupancy counter: NCHAN independent saturating channels.
// Define PROC_CTRL_CNT_HWM_EN to enable per-channel high-water marks.
module proc_ctrl_multi_cnt
    import proc_ctrl_multi_cnt_pkg::*;
#(
    parameter int unsigned NCHAN  = DEF_NCHAN,
    parameter int unsigned LIMIT  = DEF_LIMIT,
    parameter int unsigned MAXN   = DEF_MAXN,
    parameter int unsigned AF_LVL = DEF_AF_LVL,
    parameter int unsigned AE_LVL = DEF_AE_LVL
) (
    input  logic                  clk,
    input  logic                  reset,
    proc_ctrl_multi_cnt_if.slave  bus
);
    localparam int unsigned NB = ceil_log2(MAXN + 1);
    localparam int unsigned CB = ceil_log2(LIMIT + 1);

    for (genvar i = 0; i < NCHAN; i++) begin : g_chan
        proc_ctrl_cnt_chan #(
            .LIMIT  (LIMIT),
            .MAXN   (MAXN),
            .AF_LVL (AF_LVL),
            .AE_LVL (AE_LVL),
            .NB     (NB),
            .CB     (CB)
        ) u_chan (
            .clk_i          (clk),
            .rst_i          (reset),
            .enq_i          (bus.enq_n[slice_lo(i, NB) +: NB]),
            .deq_i          (bus.deq_n[slice_lo(i, NB) +: NB]),
            .flush_i        (bus.flush[i]),
            .err_clr_i      (bus.err_clr[i]),
            .count_o        (bus.count[slice_lo(i, CB) +: CB]),
            .empty_o        (bus.empty[i]),
            .full_o         (bus.full[i]),
            .almost_full_o  (bus.almost_full[i]),
            .almost_empty_o (bus.almost_empty[i]),
            .space_ok_o     (bus.space_ok[i]),
            .ovf_err_o      (bus.ovf_err[i]),
            .unf_err_o      (bus.unf_err[i]),
            .hwm_o          (bus.hwm[slice_lo(i, CB) +: CB])
        );
    end

endmodule

// File: tb/tb_proc_ctrl_multi_cnt.sv
// Directed-vector bench for proc_ctrl_multi_cnt (NCHAN=4, LIMIT=8, MAXN=2, AF=6, AE=2).
// Expected hwm depends on PROC_CTRL_CNT_HWM_EN, matching the RTL build.
module tb_proc_ctrl_multi_cnt;
    localparam int NCHAN = 4;
    localparam int NB    = 2;
    localparam int CB    = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    proc_ctrl_multi_cnt_if #(.NCHAN(NCHAN), .NB(NB), .CB(CB)) bus ();

    proc_ctrl_multi_cnt #(
        .NCHAN(NCHAN), .LIMIT(8), .MAXN(2), .AF_LVL(6), .AE_LVL(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [NB-1:0]    enq_a [NCHAN];
    logic [NB-1:0]    deq_a [NCHAN];
    logic [NCHAN-1:0] flush_a;
    logic [NCHAN-1:0] clr_a;

    for (genvar g = 0; g < NCHAN; g++) begin : g_drv
        assign bus.enq_n[g*NB +: NB] = enq_a[g];
        assign bus.deq_n[g*NB +: NB] = deq_a[g];
    end
    assign bus.flush   = flush_a;
    assign bus.err_clr = clr_a;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic idle();
        for (int i = 0; i < NCHAN; i++) begin
            enq_a[i] = '0;
            deq_a[i] = '0;
        end
        flush_a = '0;
        clr_a   = '0;
    endtask

    task automatic drv(input int ch, input int e, input int d);
        enq_a[ch] = NB'(e);
        deq_a[ch] = NB'(d);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    function automatic int cnt(input int ch);
        return int'(bus.count[ch*CB +: CB]);
    endfunction

    function automatic int hwm(input int ch);
        return int'(bus.hwm[ch*CB +: CB]);
    endfunction

    // Flags derived by hand from the expected count: LIMIT=8, AF>=6, AE<=2, space_ok<=6.
    task automatic check_state(input string tag, input int ch, input int c,
                               input int ovf, input int unf);
        check({tag, ".count"}, cnt(ch), c);
        check({tag, ".empty"}, int'(bus.empty[ch]), int'(c == 0));
        check({tag, ".full"}, int'(bus.full[ch]), int'(c == 8));
        check({tag, ".afull"}, int'(bus.almost_full[ch]), int'(c >= 6));
        check({tag, ".aempty"}, int'(bus.almost_empty[ch]), int'(c <= 2));
        check({tag, ".space"}, int'(bus.space_ok[ch]), int'(c <= 6));
        check({tag, ".ovf"}, int'(bus.ovf_err[ch]), ovf);
        check({tag, ".unf"}, int'(bus.unf_err[ch]), unf);
    endtask

    int exp_hwm1;

    initial begin
        idle();
        reset = 1'b1;
        #12;
        check_state("rst0", 0, 0, 0, 0);
        check("rst0.hwm", hwm(0), 0);
        reset = 1'b0;

        for (int k = 1; k <= 4; k++) begin
            drv(0, 2, 0);
            step();
            check_state($sformatf("fill%0d", k), 0, 2 * k, 0, 0);
        end

        drv(0, 2, 2);
        step();
        check_state("simul_full", 0, 8, 0, 0);

        for (int k = 1; k <= 4; k++) begin
            drv(0, 0, 2);
            step();
            check_state($sformatf("drain%0d", k), 0, 8 - 2 * k, 0, 0);
        end

        drv(0, 1, 1);
        step();
        check_state("simul_empty", 0, 0, 0, 0);

        drv(0, 2, 0); step();
        drv(0, 2, 0); step();
        drv(0, 2, 0); step();
        drv(0, 1, 0); step();
        check_state("cnt7", 0, 7, 0, 0);

        drv(0, 2, 0);
        step();
        check_state("ovf", 0, 8, 1, 0);
        step();
        check_state("ovf_sticky", 0, 8, 1, 0);
        clr_a[0] = 1'b1;
        step();
        check_state("ovf_clr", 0, 8, 0, 0);

        flush_a[0] = 1'b1;
        step();
        check_state("flush8", 0, 0, 0, 0);
        drv(0, 1, 0);
        step();
        check_state("cnt1", 0, 1, 0, 0);
        drv(0, 0, 2);
        step();
        check_state("unf", 0, 0, 0, 1);
        drv(0, 0, 1);
        clr_a[0] = 1'b1;
        step();
        check_state("unf_clr_vs_new", 0, 0, 0, 1);
        flush_a[0] = 1'b1;
        step();
        check_state("flush_keeps_err", 0, 0, 0, 1);
        clr_a[0] = 1'b1;
        step();
        check_state("unf_clr", 0, 0, 0, 0);

        drv(0, 2, 0); step();
        drv(0, 2, 0); step();
        drv(0, 1, 0); step();
        check_state("cnt5", 0, 5, 0, 0);
        drv(0, 2, 0);
        flush_a[0] = 1'b1;
        step();
        check_state("flush_enq", 0, 0, 0, 0);

        drv(1, 2, 0); step();
        drv(1, 2, 0); step();
        drv(1, 2, 0); step();
        drv(1, 1, 0); step();
        check_state("ch1_7", 1, 7, 0, 0);
        drv(1, 0, 2); step();
        drv(1, 0, 2); step();
        check_state("ch1_3", 1, 3, 0, 0);
        check_state("ch2_idle", 2, 0, 0, 0);
        check_state("ch0_idle", 0, 0, 0, 0);
`ifdef PROC_CTRL_CNT_HWM_EN
        exp_hwm1 = 7;
`else
        exp_hwm1 = 0;
`endif
        check("ch1.hwm", hwm(1), exp_hwm1);
        check("ch2.hwm", hwm(2), 0);

        drv(0, 2, 0); step();
        drv(0, 2, 0); step();
        drv(0, 1, 0);
        drv(2, 0, 1);
        step();
        check_state("pre_rst_ch0", 0, 5, 0, 0);
        check_state("pre_rst_ch2", 2, 0, 0, 1);
        reset = 1'b1;
        #1;
        check_state("async_rst_ch0", 0, 0, 0, 0);
        check_state("async_rst_ch1", 1, 0, 0, 0);
        check_state("async_rst_ch2", 2, 0, 0, 0);
        check("async_rst.hwm1", hwm(1), 0);
        drv(0, 2, 0);
        @(posedge clk);
        #1;
        check_state("held_rst_ch0", 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        drv(0, 1, 0);
        step();
        check_state("post_rst", 0, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
